// File: rtl/tx_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the tx rate arbiter.
package tx_arb_pkg;

   localparam int BEAT_CNT_W = 16;
   localparam int GAP_CNT_W  = 32;
   localparam int SHIFT_W    = 4;
   localparam int MAX_PORTS  = 8;
   localparam int PICK_W     = 3;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_t;

   // First set bit of eligible, searching upward from last_grant+1 and wrapping at num_ports.
   function automatic logic [PICK_W-1:0] rr_pick(
      input logic [MAX_PORTS-1:0] eligible,
      input logic [PICK_W-1:0]    last_grant,
      input int                   num_ports
   );
      logic [PICK_W-1:0] pick;
      logic              found;
      int                idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= MAX_PORTS; i++) begin
         idx = (int'(last_grant) + i) % num_ports;
         if (!found && (i <= num_ports) && eligible[idx[PICK_W-1:0]]) begin
            pick  = idx[PICK_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/tx_arb_gap_timer.sv
// Per-port inter-packet gap counter: load on packet end, count down to zero, held clear when pacing is off.
// A load beats a decrement in the same cycle; gap_zero is combinational from the registered count.
module tx_arb_gap_timer
   import tx_arb_pkg::*;
(
   input  logic                 axi_aclk,
   input  logic                 axi_reset,
   input  logic                 rate_lim_en,
   input  logic                 load,
   input  logic [GAP_CNT_W-1:0] load_val,
   output logic                 gap_zero
);

   logic [GAP_CNT_W-1:0] gap_cnt;

   always_ff @(posedge axi_aclk) begin
      if (axi_reset || !rate_lim_en) begin
         gap_cnt <= '0;
      end else if (load) begin
         gap_cnt <= load_val;
      end else if (gap_cnt != '0) begin
         gap_cnt <= gap_cnt - 1'b1;
      end
   end

   assign gap_zero = (gap_cnt == '0) || !rate_lim_en;

endmodule

// File: rtl/tx_rate_arbiter.sv
// Packet-boundary round-robin egress arbiter with per-port inter-packet gap pacing.
// One IDLE bubble per packet; egress tready passes straight through to the granted port only.
module tx_rate_arbiter
   import tx_arb_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_PORTS          = 4,
   parameter int C_S_AXI_DATA_WIDTH = 32
)(
   input  logic                                      axi_aclk,
   input  logic                                      axi_reset,
   input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
   output logic [NUM_PORTS-1:0]                      s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
   output logic                                      m_axis_tvalid,
   output logic                                      m_axis_tlast,
   input  logic                                      m_axis_tready,
   input  logic [NUM_PORTS-1:0]                      port_en,
   input  logic [NUM_PORTS-1:0]                      rate_lim_en,
   input  logic [NUM_PORTS*SHIFT_W-1:0]              rate_shift,
   output logic [NUM_PORTS*C_S_AXI_DATA_WIDTH-1:0]   pkt_count
);

   localparam int PW     = $clog2(NUM_PORTS);
   localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

   arb_state_t                    state, state_nxt;
   logic [PW-1:0]                 g, g_nxt;
   logic [PW-1:0]                 last_grant, last_grant_nxt;
   logic [PW-1:0]                 sel;
   logic [MAX_PORTS-1:0]          elig;
   logic [NUM_PORTS-1:0]          gap_zero;
   logic                          send_act;
   logic                          grant;
   logic                          hs;
   logic                          tlast_hs;
   logic [BEAT_CNT_W-1:0]         beat_cnt;
   logic [SHIFT_W-1:0]            g_shift;
   logic [GAP_CNT_W-1:0]          gap_load_val;
   logic [C_S_AXI_DATA_WIDTH-1:0] pkt_cnt_q [NUM_PORTS];

   always_comb begin
      elig                  = '0;
      elig[NUM_PORTS-1:0]   = s_axis_tvalid & port_en & gap_zero;
   end

   // Reset forces outputs quiet in the same cycle, not just after the edge.
   assign send_act = (state == SEND) && !axi_reset;
   assign sel      = send_act ? g : '0;

   always_comb begin
      m_axis_tdata  = s_axis_tdata[sel*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
      m_axis_tstrb  = s_axis_tstrb[sel*STRB_W +: STRB_W];
      m_axis_tuser  = s_axis_tuser[sel*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
      m_axis_tvalid = send_act && s_axis_tvalid[sel];
      m_axis_tlast  = send_act && s_axis_tlast[sel];
      s_axis_tready = '0;
      if (send_act) begin
         s_axis_tready[sel] = m_axis_tready;
      end
   end

   assign hs       = m_axis_tvalid && m_axis_tready;
   assign tlast_hs = hs && m_axis_tlast;

   always_comb begin
      state_nxt      = state;
      g_nxt          = g;
      last_grant_nxt = last_grant;
      grant          = 1'b0;
      case (state)
         IDLE: begin
            if (|elig) begin
               grant          = 1'b1;
               g_nxt          = PW'(rr_pick(elig, PICK_W'(last_grant), NUM_PORTS));
               last_grant_nxt = g_nxt;
               state_nxt      = SEND;
            end
         end
         SEND: begin
            if (tlast_hs) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state      <= IDLE;
         g          <= '0;
         last_grant <= PW'(NUM_PORTS - 1);
      end else begin
         state      <= state_nxt;
         g          <= g_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset || grant) begin
         beat_cnt <= '0;
      end else if (hs && (beat_cnt != '1)) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

   // beat_cnt has not yet counted the tlast beat, hence the +1.
   assign g_shift      = rate_shift[g*SHIFT_W +: SHIFT_W];
   assign gap_load_val = (GAP_CNT_W'(beat_cnt) + GAP_CNT_W'(1)) << g_shift;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      tx_arb_gap_timer u_gap_timer (
         .axi_aclk    (axi_aclk),
         .axi_reset   (axi_reset),
         .rate_lim_en (rate_lim_en[p]),
         .load        (tlast_hs && (g == PW'(p)) && rate_lim_en[p]),
         .load_val    (gap_load_val),
         .gap_zero    (gap_zero[p])
      );

      always_ff @(posedge axi_aclk) begin
         if (axi_reset) begin
            pkt_cnt_q[p] <= '0;
         end else if (tlast_hs && (g == PW'(p))) begin
            pkt_cnt_q[p] <= pkt_cnt_q[p] + 1'b1;
         end
      end

      assign pkt_count[p*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = pkt_cnt_q[p];
   end

endmodule

// File: tb/tb_tx_rate_arbiter.sv
// Bench for tx_rate_arbiter: table vectors, directed corner sequences and a randomized run
// checked every cycle against a cycle-timestamp reference model of the arbitration rules.
module tb_tx_rate_arbiter;

   localparam int NP = 4;
   localparam int DW = 256;
   localparam int UW = 128;
   localparam int SW = 32;

   logic                 axi_aclk = 1'b0;
   logic                 axi_reset;
   logic [NP*DW-1:0]     s_axis_tdata;
   logic [NP*DW/8-1:0]   s_axis_tstrb;
   logic [NP*UW-1:0]     s_axis_tuser;
   logic [NP-1:0]        s_axis_tvalid;
   logic [NP-1:0]        s_axis_tlast;
   logic [NP-1:0]        s_axis_tready;
   logic [DW-1:0]        m_axis_tdata;
   logic [DW/8-1:0]      m_axis_tstrb;
   logic [UW-1:0]        m_axis_tuser;
   logic                 m_axis_tvalid;
   logic                 m_axis_tlast;
   logic                 m_axis_tready;
   logic [NP-1:0]        port_en;
   logic [NP-1:0]        rate_lim_en;
   logic [NP*4-1:0]      rate_shift;
   logic [NP*SW-1:0]     pkt_count;

   always #5 axi_aclk = ~axi_aclk;

   tx_rate_arbiter #(
      .C_AXIS_DATA_WIDTH  (DW),
      .C_AXIS_TUSER_WIDTH (UW),
      .NUM_PORTS          (NP),
      .C_S_AXI_DATA_WIDTH (SW)
   ) dut (
      .axi_aclk      (axi_aclk),
      .axi_reset     (axi_reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .port_en       (port_en),
      .rate_lim_en   (rate_lim_en),
      .rate_shift    (rate_shift),
      .pkt_count     (pkt_count)
   );

   int n_cmp = 0;
   int n_err = 0;

   // stimulus knobs
   int            k_pct [NP];
   int            k_len [NP];
   int            k_rdy_mode;
   logic          k_reset;
   logic [NP-1:0] k_en;
   logic [NP-1:0] k_rle;
   logic [NP*4-1:0] k_shift;
   logic          rdy_phase;

   // per-port packet sources
   int src_beat [NP];
   int src_len  [NP];
   int src_pkt  [NP];

   // reference model: active port (-1 when none), previous grant, beats so far, counters,
   // and the first cycle number at which each port leaves its gap
   int     m_cur;
   int     m_last;
   int     m_beats;
   int     m_cnt  [NP];
   longint m_elig [NP];
   longint cyc;

   logic [NP-1:0] obs_rdy;
   int     ev_port [$];
   longint ev_cyc  [$];
   int     rx_beats [$];

   typedef struct {
      int       prime;
      logic [3:0] vld;
      logic [3:0] en;
      logic [3:0] exp_rdy;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] gen_tag(input int p, input int pkt, input int beat);
      return {8'(p), 16'(pkt), 16'(beat)};
   endfunction

   function automatic int new_len(input int p);
      return (k_len[p] == 0) ? int'($urandom_range(6, 1)) : k_len[p];
   endfunction

   task automatic set_src(input int p, input int len);
      k_len[p]    = len;
      src_beat[p] = 0;
      src_len[p]  = new_len(p);
   endtask

   task automatic step();
      logic [NP-1:0] vld;
      logic [NP-1:0] elig;
      logic [NP-1:0] exp_rdy;
      logic          exp_vld;
      logic [39:0]   tag;
      logic [279:0]  rep_d;
      logic [159:0]  rep_u;
      int            pick;
      longint        gap;
      @(posedge axi_aclk);
      #1;
      axi_reset = k_reset;
      for (int p = 0; p < NP; p++) begin
         vld[p] = (k_pct[p] >= 100) ? 1'b1 : (int'($urandom_range(99)) < k_pct[p]);
         tag    = gen_tag(p, src_pkt[p], src_beat[p]);
         rep_d  = {7{tag}};
         rep_u  = {4{~tag}};
         s_axis_tdata[p*DW +: DW]     = rep_d[DW-1:0];
         s_axis_tuser[p*UW +: UW]     = rep_u[UW-1:0];
         s_axis_tstrb[p*DW/8 +: DW/8] = tag[31:0] ^ 32'hA5A5_A5A5;
         s_axis_tlast[p]              = (src_beat[p] == src_len[p] - 1);
      end
      s_axis_tvalid = vld;
      port_en       = k_en;
      rate_lim_en   = k_rle;
      rate_shift    = k_shift;
      case (k_rdy_mode)
         0: m_axis_tready = 1'b1;
         1: begin
            m_axis_tready = rdy_phase;
            rdy_phase     = !rdy_phase;
         end
         default: m_axis_tready = 1'($urandom_range(1));
      endcase

      @(negedge axi_aclk);
      exp_vld = 1'b0;
      exp_rdy = '0;
      if (!k_reset && m_cur >= 0) begin
         exp_vld        = vld[m_cur];
         exp_rdy[m_cur] = m_axis_tready;
      end
      chk("m_axis_tvalid", m_axis_tvalid, exp_vld);
      chk("s_axis_tready", s_axis_tready, exp_rdy);
      if (exp_vld) begin
         chk("m_axis_tlast", m_axis_tlast, s_axis_tlast[m_cur]);
         chk("m_axis_tdata", m_axis_tdata, s_axis_tdata[m_cur*DW +: DW]);
         chk("m_axis_tuser", m_axis_tuser, s_axis_tuser[m_cur*UW +: UW]);
         chk("m_axis_tstrb", m_axis_tstrb, s_axis_tstrb[m_cur*DW/8 +: DW/8]);
      end else begin
         chk("m_axis_tlast_idle", m_axis_tlast && m_axis_tvalid, 1'b0);
      end
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("pkt_count[%0d]", p), pkt_count[p*SW +: SW], SW'(m_cnt[p]));
      end
      obs_rdy = s_axis_tready;

      if (m_axis_tvalid && m_axis_tready) begin
         rx_beats.push_back(int'(m_axis_tdata[15:0]));
         if (m_axis_tlast) begin
            pick = -1;
            for (int p = 0; p < NP; p++) if (s_axis_tready[p]) pick = p;
            ev_port.push_back(pick);
            ev_cyc.push_back(cyc);
         end
      end

      for (int p = 0; p < NP; p++) begin
         if (s_axis_tvalid[p] && s_axis_tready[p]) begin
            if (s_axis_tlast[p]) begin
               src_beat[p] = 0;
               src_pkt[p]++;
               src_len[p]  = new_len(p);
            end else begin
               src_beat[p]++;
            end
         end
      end

      if (k_reset) begin
         m_cur  = -1;
         m_last = NP - 1;
         for (int p = 0; p < NP; p++) begin
            m_cnt[p]  = 0;
            m_elig[p] = 0;
         end
      end else if (m_cur < 0) begin
         for (int p = 0; p < NP; p++)
            elig[p] = vld[p] && k_en[p] && (!k_rle[p] || cyc >= m_elig[p]);
         pick = -1;
         for (int i = 1; i <= NP; i++) begin
            int q;
            q = (m_last + i) % NP;
            if (pick < 0 && elig[q]) pick = q;
         end
         if (pick >= 0) begin
            m_cur   = pick;
            m_last  = pick;
            m_beats = 0;
         end
      end else if (vld[m_cur] && m_axis_tready) begin
         m_beats++;
         if (s_axis_tlast[m_cur]) begin
            m_cnt[m_cur]++;
            if (k_rle[m_cur]) begin
               gap = longint'((m_beats > 65536) ? 65536 : m_beats) << k_shift[m_cur*4 +: 4];
               m_elig[m_cur] = cyc + 1 + (gap & 64'hFFFF_FFFF);
            end
            m_cur = -1;
         end
      end
      for (int p = 0; p < NP; p++) if (!k_rle[p]) m_elig[p] = 0;
      cyc++;
   endtask

   task automatic clear_obs();
      ev_port.delete();
      ev_cyc.delete();
      rx_beats.delete();
   endtask

   task automatic do_reset();
      k_pct      = '{default: 0};
      k_en       = '1;
      k_rle      = '0;
      k_shift    = '0;
      k_rdy_mode = 0;
      rdy_phase  = 1'b1;
      k_reset    = 1'b1;
      step();
      step();
      k_reset = 1'b0;
      for (int p = 0; p < NP; p++) set_src(p, 1);
      clear_obs();
   endtask

   task automatic run_until_events(input int n, input int budget);
      for (int i = 0; i < budget && ev_port.size() < n; i++) step();
   endtask

   initial begin
      int cnt0;
      axi_reset     = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tstrb  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      m_axis_tready = 1'b0;
      port_en       = '0;
      rate_lim_en   = '0;
      rate_shift    = '0;
      k_len         = '{default: 1};
      src_beat      = '{default: 0};
      src_len       = '{default: 1};
      src_pkt       = '{default: 0};
      m_cnt         = '{default: 0};
      m_elig        = '{default: 0};
      m_cur         = -1;
      m_last        = NP - 1;
      m_beats       = 0;
      cyc           = 0;

      tbl[0] = '{-1, 4'b1111, 4'b1111, 4'b0001};
      tbl[1] = '{-1, 4'b1100, 4'b1111, 4'b0100};
      tbl[2] = '{-1, 4'b1111, 4'b0110, 4'b0010};
      tbl[3] = '{ 1, 4'b1111, 4'b1111, 4'b0100};
      tbl[4] = '{ 3, 4'b1010, 4'b1111, 4'b0010};
      tbl[5] = '{ 2, 4'b0101, 4'b1111, 4'b0001};
      tbl[6] = '{ 0, 4'b0001, 4'b1111, 4'b0001};
      tbl[7] = '{-1, 4'b0000, 4'b1111, 4'b0000};

      // grant selection from reset and after a primed last_grant
      for (int i = 0; i < 8; i++) begin
         do_reset();
         if (tbl[i].prime >= 0) begin
            k_pct[tbl[i].prime] = 100;
            run_until_events(1, 10);
            chk("tbl_prime_pkt", ev_port.size(), 1);
         end
         for (int p = 0; p < NP; p++) k_pct[p] = tbl[i].vld[p] ? 100 : 0;
         k_en = tbl[i].en;
         step();
         step();
         chk($sformatf("tbl[%0d]_grant", i), obs_rdy, tbl[i].exp_rdy);
      end

      // round-robin with 2-beat packets, 3 cycles per packet
      do_reset();
      for (int p = 0; p < NP; p++) begin
         set_src(p, 2);
         k_pct[p] = 100;
      end
      for (int i = 0; i < 36; i++) step();
      chk("rr_pkts", ev_port.size(), 12);
      for (int i = 0; i < ev_port.size(); i++) begin
         chk($sformatf("rr_order[%0d]", i), ev_port[i], i % NP);
         if (i > 0) chk($sformatf("rr_spacing[%0d]", i), ev_cyc[i] - ev_cyc[i-1], 3);
      end
      k_pct = '{default: 0};
      step();
      for (int p = 0; p < NP; p++) chk($sformatf("rr_count[%0d]", p), pkt_count[p*SW +: SW], 3);

      // rate limiting: 8 beats << 3 = 64 gap cycles
      do_reset();
      set_src(1, 8);
      k_pct[1]     = 100;
      k_rle[1]     = 1'b1;
      k_shift[7:4] = 4'd3;
      run_until_events(2, 200);
      chk("gap_pkts", ev_port.size(), 2);
      if (ev_cyc.size() >= 2) chk("gap_tlast_spacing", ev_cyc[1] - ev_cyc[0], 73);

      // egress backpressure toggling on port 2
      do_reset();
      set_src(2, 4);
      k_pct[2]   = 100;
      k_rdy_mode = 1;
      run_until_events(1, 30);
      chk("bp_pkts", ev_port.size(), 1);
      chk("bp_beats", rx_beats.size(), 4);
      for (int i = 0; i < rx_beats.size(); i++) chk($sformatf("bp_beat[%0d]", i), rx_beats[i], i);
      step();
      chk("bp_count2", pkt_count[2*SW +: SW], 1);

      // port_en dropped mid-packet: packet completes, port then never granted
      do_reset();
      set_src(0, 5);
      set_src(1, 5);
      k_pct[0] = 100;
      k_pct[1] = 100;
      for (int i = 0; i < 20 && src_beat[0] != 2; i++) step();
      chk("dis_reach_beat2", src_beat[0], 2);
      k_en[0] = 1'b0;
      for (int i = 0; i < 60; i++) step();
      cnt0 = 0;
      foreach (ev_port[i]) if (ev_port[i] == 0) cnt0++;
      chk("dis_port0_pkts", cnt0, 1);
      chk("dis_count0", pkt_count[0 +: SW], 1);
      for (int i = 0; i < 5 && i < rx_beats.size(); i++) chk($sformatf("dis_beat[%0d]", i), rx_beats[i], i);

      // port 0 in its gap is skipped, then taken on the first IDLE after the gap
      do_reset();
      set_src(0, 2);
      set_src(1, 3);
      k_pct[0]     = 100;
      k_pct[1]     = 100;
      k_rle[0]     = 1'b1;
      k_shift[3:0] = 4'd2;
      run_until_events(4, 60);
      chk("skip_pkts", ev_port.size(), 4);
      if (ev_port.size() >= 4) begin
         chk("skip_order0", ev_port[0], 0);
         chk("skip_order1", ev_port[1], 1);
         chk("skip_order2", ev_port[2], 1);
         chk("skip_order3", ev_port[3], 0);
         chk("skip_p0_spacing", ev_cyc[3] - ev_cyc[0], 11);
      end

      // reset asserted for one cycle at beat 3
      do_reset();
      set_src(0, 6);
      set_src(1, 6);
      k_pct[0] = 100;
      k_pct[1] = 100;
      for (int i = 0; i < 20 && src_beat[0] != 3; i++) step();
      chk("rst_reach_beat3", src_beat[0], 3);
      step();
      k_reset = 1'b1;
      step();
      k_reset  = 1'b0;
      k_pct[0] = 0;
      clear_obs();
      step();
      chk("rst_tvalid_after", m_axis_tvalid, 1'b0);
      chk("rst_count0_after", pkt_count[0 +: SW], 0);
      run_until_events(1, 20);
      chk("rst_next_pkts", ev_port.size(), 1);
      if (ev_port.size() >= 1) chk("rst_next_grant", ev_port[0], 1);

      // randomized traffic against the reference model
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         for (int p = 0; p < NP; p++) begin
            k_pct[p]         = int'($urandom_range(100, 20));
            k_len[p]         = 0;
            k_en[p]          = ($urandom_range(9) != 0);
            k_rle[p]         = 1'($urandom_range(1));
            k_shift[p*4 +: 4] = 4'($urandom_range(3));
         end
         k_rdy_mode = ($urandom_range(1) != 0) ? 2 : 0;
         for (int i = 0; i < 200; i++) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
